// File: rtl/tick_stopwatch_pkg.sv
// Shared definitions for the tick-driven BCD MM:SS stopwatch.
// FSM state encoding, BCD digit width and the per-digit wrap limits.
package tick_stopwatch_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVF   = 2'd3
    } state_t;

    localparam logic [BCD_W-1:0] SEC_ONES_MAX = 4'd9;
    localparam logic [BCD_W-1:0] SEC_TENS_MAX = 4'd5;
    localparam logic [BCD_W-1:0] MIN_ONES_MAX = 4'd9;
    localparam logic [BCD_W-1:0] MIN_TENS_MAX = 4'd9;

endpackage

// File: rtl/tick_stopwatch_if.sv
// Command pulses into the stopwatch and the displayed/captured time out of it.
// slave: the stopwatch itself; master: whoever issues commands and reads the time.
interface tick_stopwatch_if;
    import tick_stopwatch_pkg::*;

    logic             tick;
    logic             start_stop;
    logic             clear;
    logic             lap;

    logic [BCD_W-1:0] sec_ones;
    logic [BCD_W-1:0] sec_tens;
    logic [BCD_W-1:0] min_ones;
    logic [BCD_W-1:0] min_tens;
    logic             running;
    logic             overflow;

    logic [BCD_W-1:0] lap_sec_ones;
    logic [BCD_W-1:0] lap_sec_tens;
    logic [BCD_W-1:0] lap_min_ones;
    logic [BCD_W-1:0] lap_min_tens;
    logic             lap_valid;

    modport slave (
        input  tick, start_stop, clear, lap,
        output sec_ones, sec_tens, min_ones, min_tens, running, overflow,
        output lap_sec_ones, lap_sec_tens, lap_min_ones, lap_min_tens, lap_valid
    );

    modport master (
        output tick, start_stop, clear, lap,
        input  sec_ones, sec_tens, min_ones, min_tens, running, overflow,
        input  lap_sec_ones, lap_sec_tens, lap_min_ones, lap_min_tens, lap_valid
    );

endinterface

// File: rtl/tick_stopwatch_bcd_digit.sv
// One BCD digit of the stopwatch: increments on inc, wraps to 0 past limit
// and reports the wrap as a same-cycle carry into the next digit.
module bcd_digit
    import tick_stopwatch_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic [BCD_W-1:0] limit,
    output logic [BCD_W-1:0] q,
    output logic             carry
);

    assign carry = inc & (q == limit);

    // Digit register: synchronous clear has priority over increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc) begin
            q <= (q == limit) ? '0 : q + 4'd1;
        end
    end

endmodule

// File: rtl/tick_stopwatch.sv
// BCD MM:SS stopwatch counting 1 s ticks from the upstream prescaler.
// Start/pause/clear FSM, saturating at MAX_MIN:59.
// Optional lap capture is compiled in with `define STOPWATCH_LAP_EN.
//
//  state | meaning
//  IDLE  | cleared, waiting for start_stop
//  RUN   | counting ticks
//  PAUSE | holding time, start_stop resumes
//  OVF   | saturated at MAX_MIN:59, only clear leaves
module tick_stopwatch
    import tick_stopwatch_pkg::*;
#(
    parameter int MAX_MIN = 99
) (
    input  logic            clk,
    input  logic            rst,
    tick_stopwatch_if.slave sw
);

    localparam logic [BCD_W-1:0] MAX_MIN_TENS = 4'(MAX_MIN / 10);
    localparam logic [BCD_W-1:0] MAX_MIN_ONES = 4'(MAX_MIN % 10);

    state_t           state;
    state_t           state_nx;
    logic             cnt_en;
    logic             at_max;
    logic             running_q;
    logic             overflow_q;

    logic [BCD_W-1:0] so_q;
    logic [BCD_W-1:0] st_q;
    logic [BCD_W-1:0] mo_q;
    logic [BCD_W-1:0] mt_q;
    logic             so_carry;
    logic             st_carry;
    logic             mo_carry;
    logic             mt_carry;

    assign at_max = (so_q == SEC_ONES_MAX) && (st_q == SEC_TENS_MAX) &&
                    (mo_q == MAX_MIN_ONES) && (mt_q == MAX_MIN_TENS);

    // Next state and count enable; a tick at the maximum diverts to OVF
    // instead of incrementing, so the digits never wrap.
    always_comb begin
        state_nx = state;
        cnt_en   = 1'b0;
        if (sw.clear) begin
            state_nx = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE, ST_PAUSE: begin
                    if (sw.start_stop) state_nx = ST_RUN;
                end
                ST_RUN: begin
                    if (sw.tick && at_max) begin
                        state_nx = ST_OVF;
                    end else begin
                        cnt_en = sw.tick;
                        if (sw.start_stop) state_nx = ST_PAUSE;
                    end
                end
                ST_OVF: begin
                    state_nx = ST_OVF;
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    // State register with registered status flags decoded from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            running_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state      <= state_nx;
            running_q  <= (state_nx == ST_RUN);
            overflow_q <= (state_nx == ST_OVF);
        end
    end

    bcd_digit u_sec_ones (
        .clk   (clk),
        .rst   (rst),
        .clr   (sw.clear),
        .inc   (cnt_en),
        .limit (SEC_ONES_MAX),
        .q     (so_q),
        .carry (so_carry)
    );

    bcd_digit u_sec_tens (
        .clk   (clk),
        .rst   (rst),
        .clr   (sw.clear),
        .inc   (so_carry),
        .limit (SEC_TENS_MAX),
        .q     (st_q),
        .carry (st_carry)
    );

    bcd_digit u_min_ones (
        .clk   (clk),
        .rst   (rst),
        .clr   (sw.clear),
        .inc   (st_carry),
        .limit (MIN_ONES_MAX),
        .q     (mo_q),
        .carry (mo_carry)
    );

    // Top digit carry is unreachable: saturation stops counting first.
    bcd_digit u_min_tens (
        .clk   (clk),
        .rst   (rst),
        .clr   (sw.clear),
        .inc   (mo_carry),
        .limit (MIN_TENS_MAX),
        .q     (mt_q),
        .carry (mt_carry)
    );

    assign sw.sec_ones = so_q;
    assign sw.sec_tens = st_q;
    assign sw.min_ones = mo_q;
    assign sw.min_tens = mt_q;
    assign sw.running  = running_q;
    assign sw.overflow = overflow_q;

`ifdef STOPWATCH_LAP_EN
    logic [BCD_W-1:0] lap_so_q;
    logic [BCD_W-1:0] lap_st_q;
    logic [BCD_W-1:0] lap_mo_q;
    logic [BCD_W-1:0] lap_mt_q;
    logic             lap_valid_q;

    // Lap capture of the currently displayed (pre-increment) time.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lap_so_q    <= '0;
            lap_st_q    <= '0;
            lap_mo_q    <= '0;
            lap_mt_q    <= '0;
            lap_valid_q <= 1'b0;
        end else if (sw.clear) begin
            lap_so_q    <= '0;
            lap_st_q    <= '0;
            lap_mo_q    <= '0;
            lap_mt_q    <= '0;
            lap_valid_q <= 1'b0;
        end else if (sw.lap && (state != ST_IDLE)) begin
            lap_so_q    <= so_q;
            lap_st_q    <= st_q;
            lap_mo_q    <= mo_q;
            lap_mt_q    <= mt_q;
            lap_valid_q <= 1'b1;
        end
    end

    assign sw.lap_sec_ones = lap_so_q;
    assign sw.lap_sec_tens = lap_st_q;
    assign sw.lap_min_ones = lap_mo_q;
    assign sw.lap_min_tens = lap_mt_q;
    assign sw.lap_valid    = lap_valid_q;
`else
    assign sw.lap_sec_ones = '0;
    assign sw.lap_sec_tens = '0;
    assign sw.lap_min_ones = '0;
    assign sw.lap_min_tens = '0;
    assign sw.lap_valid    = 1'b0;
`endif

endmodule
